// File: rtl/twiddle_addr_gen_pkg.sv
// Shared types and helpers for the twiddle address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package twiddle_addr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the stage number field; stages run 1..log2(N).
    localparam int STAGE_W = 4;

    // log2 of a legal (power-of-two) FFT size: index of the highest set bit.
    function automatic logic [STAGE_W-1:0] size_log2(input logic [15:0] n);
        logic [STAGE_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (n[i]) r = STAGE_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/twiddle_addr_gen_twiddle.sv
// Twiddle ROM: W_m^k = cos(2*pi*k/m) - j*sin(2*pi*k/m) as packed FP8 (E4M3) or FP4 (E2M1) pair.
// Latency: combinational; the caller registers the result alongside k and m.
// Backpressure: none, pure lookup.
module twiddle_factor_unified #(
    parameter int MAX_N      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int PRECISION  = 0
) (
    input  logic [ADDR_WIDTH-1:0] k,
    input  logic [ADDR_WIDTH:0]   m,
    output logic [15:0]           twiddle
);

    localparam int     QTR         = MAX_N / 4;
    localparam int     IDX_W       = $clog2(QTR + 1);
    localparam int     MAG_W       = (PRECISION == 1) ? 7 : 3;
    localparam longint ONE_Q30     = 64'sd1 <<< 30;
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // cos(pi/2 * i / QTR) in Q30, Taylor series; only evaluated at elaboration.
    function automatic longint cos_q30(input int i);
        longint x, x2, term, sum;
        x    = (HALF_PI_Q30 * longint'(i)) / longint'(QTR);
        x2   = (x * x) >>> 30;
        term = ONE_Q30;
        sum  = ONE_Q30;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        if (sum < 0)       sum = 0;
        if (sum > ONE_Q30) sum = ONE_Q30;
        return sum;
    endfunction

    // Round a Q30 magnitude in [0,1] to E4M3 exponent+mantissa bits (bias 7).
    // Mantissa rounding that overflows carries naturally into the exponent field.
    function automatic logic [6:0] fp8_mag(input longint v);
        int     sh;
        longint frac, mant;
        if (v <= 0) return 7'd0;
        sh = 7;
        for (int i = 6; i >= 0; i--) begin
            if (v >= (ONE_Q30 >>> i)) sh = i;
        end
        if (sh == 7) begin
            mant = (v + (64'sd1 <<< 20)) >>> 21;
            return 7'(mant);
        end
        frac = (v <<< sh) - ONE_Q30;
        mant = (frac + (64'sd1 <<< 26)) >>> 27;
        return 7'(longint'((7 - sh) * 8) + mant);
    endfunction

    // Round a Q30 magnitude in [0,1] to the nearest of E2M1 {0, 0.5, 1.0}.
    function automatic logic [2:0] fp4_mag(input longint v);
        if (v < ONE_Q30 / 4)       return 3'd0;
        if (v < (3 * ONE_Q30) / 4) return 3'd1;
        return 3'd2;
    endfunction

    logic [MAG_W-1:0] mag_tab [0:QTR];

    for (genvar gi = 0; gi <= QTR; gi++) begin : g_tab
        localparam longint C = cos_q30(gi);
        assign mag_tab[gi] = (PRECISION == 1) ? MAG_W'(fp8_mag(C)) : MAG_W'(fp4_mag(C));
    end

    logic [ADDR_WIDTH-1:0] phase, off, comp;
    logic [1:0]            quad;
    logic [MAG_W-1:0]      mag_a, mag_b, re_mag, im_mag;
    logic                  re_neg, im_neg;

    // Fold the angle onto a quarter-wave table and rebuild the signed pair.
    always_comb begin
        phase = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            if (m[i]) phase = k << (ADDR_WIDTH - i);
        end
        quad   = phase[ADDR_WIDTH-1 -: 2];
        off    = phase & ADDR_WIDTH'(QTR - 1);
        comp   = ADDR_WIDTH'(QTR) - off;
        mag_a  = mag_tab[IDX_W'(off)];
        mag_b  = mag_tab[IDX_W'(comp)];
        re_mag = quad[0] ? mag_b : mag_a;
        im_mag = quad[0] ? mag_a : mag_b;
        re_neg = (quad == 2'd1 || quad == 2'd2) && (re_mag != '0);
        im_neg = (quad == 2'd0 || quad == 2'd1) && (im_mag != '0);
        if (PRECISION == 1)
            twiddle = {re_neg, 7'(re_mag), im_neg, 7'(im_mag)};
        else
            twiddle = {8'h00, re_neg, 3'(re_mag), im_neg, 3'(im_mag)};
    end

endmodule

// File: rtl/twiddle_addr_gen.sv
// Radix-2 DIT twiddle sequencer: emits (k, m, stage, W_m^k) for every butterfly of an N-point FFT.
// Latency: first item valid the cycle after start; one item per cycle while out_ready is high.
// Backpressure: valid/ready; all out_* fields hold while out_valid=1 and out_ready=0. Optional TWGEN_INVERSE_EN adds an inverse port.
module twiddle_addr_gen
    import twiddle_addr_gen_pkg::*;
#(
    parameter int MAX_N      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int PRECISION  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_cfg,
`ifdef TWGEN_INVERSE_EN
    input  logic                  inverse,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_k,
    output logic [ADDR_WIDTH:0]   out_n,
    output logic [STAGE_W-1:0]    out_stage,
    output logic [15:0]           out_twiddle,
    output logic                  out_last_stage,
    output logic                  out_last
);

    localparam int NW = ADDR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [NW-1:0]         n_q;
    logic [STAGE_W-1:0]    log_n_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    logic                  idle, hsk, start_ok, n_legal, load;
    logic [NW-1:0]         sel_n, nx_m;
    logic [STAGE_W-1:0]    sel_log, nx_stage;
    logic [ADDR_WIDTH-1:0] nx_cnt, nx_k;
    logic                  nx_last_stage, nx_last, inv_sel;
    logic [15:0]           rom_tw, tw_d;

    // Start qualification and handshake decode.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        hsk      = out_valid && out_ready;
        start_ok = idle && start;
        n_legal  = (n_cfg >= NW'(2)) && (n_cfg <= NW'(MAX_N))
                   && ((n_cfg & (n_cfg - NW'(1))) == '0);
        load     = (start_ok && n_legal) || ((state_q == ST_RUN) && hsk && !out_last);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = n_legal ? ST_RUN : ST_DONE;
            ST_RUN: begin
                busy = 1'b1;
                if (hsk && out_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next item: the first one when starting, otherwise the successor of the item on the output.
    // cnt walks 0..N/2-1 within a stage; k is its low (s-1) bits since groups repeat j=0..m/2-1.
    always_comb begin
        sel_n   = idle ? n_cfg : n_q;
        sel_log = idle ? size_log2(16'(n_cfg)) : log_n_q;
        if (idle) begin
            nx_cnt   = '0;
            nx_stage = STAGE_W'(1);
        end else if (out_last_stage) begin
            nx_cnt   = '0;
            nx_stage = out_stage + STAGE_W'(1);
        end else begin
            nx_cnt   = cnt_q + ADDR_WIDTH'(1);
            nx_stage = out_stage;
        end
        nx_m          = NW'(1) << nx_stage;
        nx_k          = nx_cnt & ADDR_WIDTH'((nx_m >> 1) - NW'(1));
        nx_last_stage = ({1'b0, nx_cnt} == ((sel_n >> 1) - NW'(1)));
        nx_last       = nx_last_stage && (nx_stage == sel_log);
    end

    twiddle_factor_unified #(
        .MAX_N      (MAX_N),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PRECISION  (PRECISION)
    ) u_twiddle (
        .k       (nx_k),
        .m       (nx_m),
        .twiddle (rom_tw)
    );

`ifdef TWGEN_INVERSE_EN
    logic inv_q;

    // Direction is latched with the size so a sequence is all-forward or all-inverse.
    always_ff @(posedge clk) begin
        if (rst)           inv_q <= 1'b0;
        else if (start_ok) inv_q <= inverse;
    end

    assign inv_sel = idle ? inverse : inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    // Conjugate for inverse transforms; a zero imaginary part keeps a positive sign.
    always_comb begin
        tw_d = rom_tw;
        if (inv_sel) begin
            if (PRECISION == 1) begin
                if (rom_tw[6:0] != '0) tw_d[7] = ~rom_tw[7];
            end else begin
                if (rom_tw[2:0] != '0) tw_d[3] = ~rom_tw[3];
            end
        end
    end

    // Output register: loads the next item on start or handshake, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            err            <= 1'b0;
            n_q            <= '0;
            log_n_q        <= '0;
            cnt_q          <= '0;
            out_valid      <= 1'b0;
            out_k          <= '0;
            out_n          <= '0;
            out_stage      <= '0;
            out_twiddle    <= '0;
            out_last_stage <= 1'b0;
            out_last       <= 1'b0;
        end else begin
            if (start_ok) begin
                err <= !n_legal;
                if (n_legal) begin
                    n_q     <= n_cfg;
                    log_n_q <= size_log2(16'(n_cfg));
                end
            end
            if (load) begin
                cnt_q          <= nx_cnt;
                out_valid      <= 1'b1;
                out_k          <= nx_k;
                out_n          <= nx_m;
                out_stage      <= nx_stage;
                out_twiddle    <= tw_d;
                out_last_stage <= nx_last_stage;
                out_last       <= nx_last;
            end else if ((state_q == ST_RUN) && hsk) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/twiddle_addr_gen.md
TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

Interface
REQ-001 The block SHALL have parameter MAX_N, default 1024, giving the largest supported FFT size.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, equal to log2(MAX_N).
REQ-003 The block SHALL have parameter PRECISION, default 0, where 0 selects FP4 and 1 selects FP8; it is passed to the ROM.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a twiddle sequence for one FFT.
REQ-007 The block SHALL have port n_cfg, input, ADDR_WIDTH+1 bits: FFT size N, sampled on accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sequence ends.
REQ-010 The block SHALL have port err, output, 1 bit: the last start held an illegal n_cfg; held until the next accepted start.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output item is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the item.
REQ-013 The block SHALL have port out_k, output, ADDR_WIDTH bits: the twiddle index k.
REQ-014 The block SHALL have port out_n, output, ADDR_WIDTH+1 bits: the sub-FFT size m of the current stage.
REQ-015 The block SHALL have port out_stage, output, 4 bits: the stage number s, 1..log2(N).
REQ-016 The block SHALL have port out_twiddle, output, 16 bits: W_m^k in the ROM's 16-bit format.
REQ-017 The block SHALL have port out_last_stage, output, 1 bit: the item is the final item of its stage.
REQ-018 The block SHALL have port out_last, output, 1 bit: the item is the final item of the whole sequence.

Function
REQ-019 The block SHALL have states IDLE, RUN and DONE: IDLE to RUN on start with a legal n_cfg; IDLE to DONE on start with an illegal n_cfg; RUN to DONE on the handshake of the item with out_last=1; DONE to IDLE unconditionally after one cycle.
REQ-020 A legal n_cfg SHALL be a power of two from 2 to MAX_N; any other value SHALL set err=1 and produce no items.
REQ-021 The item order SHALL be radix-2 DIT: for s=1..log2(N), m=2^s; for each group g=0..N/m-1; for j=0..m/2-1, emit k=j and n=m.
REQ-022 The sequence SHALL contain exactly (N/2)*log2(N) items.
REQ-023 The first out_valid SHALL rise in the cycle after start is accepted.
REQ-024 With out_ready held at 1, one item SHALL be emitted every cycle with no bubbles, including across stage boundaries.
REQ-025 A handshake SHALL occur when out_valid=1 and out_ready=1 in the same cycle.
REQ-026 While out_valid=1 and out_ready=0, every out_* signal SHALL hold stable.
REQ-027 out_twiddle SHALL be registered in the same cycle as its out_k, out_n and out_stage, so that all output fields match.
REQ-028 start SHALL be ignored while busy=1 or while the block is in DONE.
REQ-029 busy SHALL equal 1 exactly in RUN.
REQ-030 done SHALL pulse in the cycle after the final handshake, or in the cycle after an illegal start.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL go to IDLE from any state, including mid-sequence, and abandon any pending item.
REQ-032 After reset, every output SHALL be 0, including busy, done, err, out_valid, out_k, out_n, out_stage, out_twiddle, out_last_stage and out_last.

Configuration
REQ-033 When TWGEN_INVERSE_EN is defined, the block SHALL have an input port inverse, 1 bit, sampled on accepted start; when inverse=1, the block SHALL flip the sign bit of the nonzero imaginary field of out_twiddle (bit 7 for FP8, bit 3 for FP4).
REQ-034 When TWGEN_INVERSE_EN is not defined, the block SHALL have no inverse port and SHALL output only forward twiddles.

Structure
REQ-035 A shared package SHALL hold the state encoding, the stage-width constant, and a log2-of-legal-size helper.
REQ-036 The block SHALL contain exactly one sub-module instance, twiddle_factor_unified, driven by the current k and m and with PRECISION passed through.

Verification
REQ-037 Scenario: rst, then start with n_cfg=8 and out_ready=1 -> 12 items with (k,n) = (0,2)x4, (0,4),(1,4),(0,4),(1,4), (0,8),(1,8),(2,8),(3,8); out_last on the 12th item; done one cycle later.
REQ-038 Scenario: PRECISION=1, n_cfg=4 -> item (0,2) gives out_twiddle=16'h3800; item (1,4) gives 16'h00B8; with PRECISION=0, item (0,2) gives 16'h0020.
REQ-039 Scenario: n_cfg=1024 with random out_ready -> 5120 handshakes, outputs stable during every stall, out_stage steps 1..10.
REQ-040 Scenario: start with n_cfg=12, and separately with n_cfg=0 -> no out_valid, err=1, done pulse in the next cycle.
REQ-041 Scenario: rst asserted at item 7 of N=16 -> all outputs 0 in the next cycle; a new start with n_cfg=16 then yields the full 32-item sequence.
REQ-042 Scenario: with TWGEN_INVERSE_EN defined, inverse=1, PRECISION=1, n_cfg=4 -> item (1,4) gives 16'h0038; start pulses while busy=1 are ignored.
